// File: rtl/clk_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_if
// Ratio-programming handshake used by clk_div_ctrl.
//
// Signals:
//   cfg_div    requested divide ratio (CNT_W bits)
//   cfg_valid  cfg_div is valid
//   cfg_ready  request accepted when cfg_valid && cfg_ready at a rising edge
//   cfg_err    one-cycle pulse: the accepted request carried a zero ratio
//
// Modports:
//   master  requester (software / upstream FSM)
//   slave   clk_div_ctrl
// -----------------------------------------------------------------------------
interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_div,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_div,
        input  cfg_valid,
        output cfg_ready,
        output cfg_err
    );
endinterface : clk_div_ctrl_if

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time programmable divided-clock / clock-enable generator. A small
// controller sequences start, stop and ratio changes so that every change
// lands on an output-period boundary: no runt or stretched period is produced.
//
// Ports:
//   clk_in   single clock
//   rst      asynchronous, active-high reset
//   en       run request (level); start sampled in STOP, stop sampled only
//            on period boundaries
//   cfg      ratio-programming handshake (slave side)
//   clk_out  divided clock, registered; high for the first cur_div>>1 cycles
//            of each period (constantly high while running when cur_div==1)
//   clk_en   one-cycle pulse on the last clk_in cycle of each output period
//   cur_div  ratio currently in effect
//   running  high in RUN or SWITCH
//
// All outputs are registered. They are decoded from the *next* values of
// (state, count, cur_div) and captured on the same edge as those registers,
// so each output equals a function of the current (state, count, cur_div).
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    clk_div_ctrl_if.slave     cfg,
    output logic              clk_out,
    output logic              clk_en,
    output logic [CNT_W-1:0]  cur_div,
    output logic              running
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    // Controller state
    state_t           state_q,   state_nxt;
    logic [CNT_W-1:0] count_q,   count_nxt;
    logic [CNT_W-1:0] cur_div_q, cur_div_nxt;
    logic [CNT_W-1:0] pending_q, pending_nxt;

    // Registered outputs and their next values
    logic clk_out_q,   clk_out_nxt;
    logic clk_en_q,    clk_en_nxt;
    logic running_q,   running_nxt;
    logic cfg_ready_q, cfg_ready_nxt;
    logic cfg_err_q,   cfg_err_nxt;

    // Handshake decode
    logic accept;
    logic cfg_zero;
    logic cfg_load;
    logic boundary;

    // -------------------------------------------------------------------------
    // State register (also captures the decoded outputs)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            // NOTE: pending is reset too, so a ratio queued before reset can
            // never be committed afterwards.
            state_q     <= ST_STOP;
            count_q     <= '0;
            cur_div_q   <= DEF_DIV;
            pending_q   <= '0;
            clk_out_q   <= 1'b0;
            clk_en_q    <= 1'b0;
            running_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            count_q     <= count_nxt;
            cur_div_q   <= cur_div_nxt;
            pending_q   <= pending_nxt;
            clk_out_q   <= clk_out_nxt;
            clk_en_q    <= clk_en_nxt;
            running_q   <= running_nxt;
            cfg_ready_q <= cfg_ready_nxt;
            cfg_err_q   <= cfg_err_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // cfg_ready is a registered output that is low only in SWITCH, so using
    // it here keeps the accept decode consistent with what the master sees.
    assign accept   = cfg.cfg_valid && cfg_ready_q;
    assign cfg_zero = accept && (cfg.cfg_div == '0);
    assign cfg_load = accept && (cfg.cfg_div != '0);
    // Last clk_in cycle of the current output period (only meaningful while
    // running; in STOP count is held at 0).
    assign boundary = (count_q == cur_div_q - ONE);

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state_q;
        count_nxt   = count_q;
        cur_div_nxt = cur_div_q;
        pending_nxt = pending_q;

        unique case (state_q)
            ST_STOP: begin
                count_nxt = '0;
                // Idle: a new ratio loads directly.
                if (cfg_load) begin
                    cur_div_nxt = cfg.cfg_div;
                end
                // Period starts at count 0 on the next cycle (clk_out high).
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                count_nxt = boundary ? '0 : count_q + ONE;
                if (boundary && !en) begin
                    // Stop at this boundary; a ratio accepted on the same
                    // cycle loads as it would in STOP.
                    state_nxt = ST_STOP;
                    if (cfg_load) begin
                        cur_div_nxt = cfg.cfg_div;
                    end
                end else if (cfg_load) begin
                    // Even when accepted on a boundary, the ratio waits for
                    // the following boundary so this period is not cut short.
                    pending_nxt = cfg.cfg_div;
                    state_nxt   = ST_SWITCH;
                end
            end

            ST_SWITCH: begin
                if (boundary) begin
                    count_nxt   = '0;
                    cur_div_nxt = pending_q;
                    pending_nxt = '0;
                    state_nxt   = en ? ST_RUN : ST_STOP;
                end else begin
                    count_nxt = count_q + ONE;
                end
            end

            default: begin
                state_nxt = ST_STOP;
                count_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from next-state values (registered in the block above)
    // -------------------------------------------------------------------------
    always_comb begin
        running_nxt   = (state_nxt != ST_STOP);
        // Ratio 1 has no low phase: constantly high while running.
        clk_out_nxt   = running_nxt &&
                        ((cur_div_nxt == ONE) || (count_nxt < (cur_div_nxt >> 1)));
        clk_en_nxt    = running_nxt && (count_nxt == cur_div_nxt - ONE);
        cfg_ready_nxt = (state_nxt != ST_SWITCH);
        cfg_err_nxt   = cfg_zero;
    end

    assign clk_out       = clk_out_q;
    assign clk_en        = clk_en_q;
    assign running       = running_q;
    assign cur_div       = cur_div_q;
    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed bench for clk_div_ctrl (CNT_W=8, DEFAULT_DIV=4). Inputs change #1
// after a rising edge; outputs are sampled at that same point, i.e. they
// reflect the cycle that just started.
// Observation vector: {running, clk_out, clk_en, cfg_ready, cfg_err}.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk_in;
    logic             rst;
    logic             en;
    logic             clk_out;
    logic             clk_en;
    logic [CNT_W-1:0] cur_div;
    logic             running;

    int vectors     = 0;
    int miscompares = 0;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg ();

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .cfg     (cfg),
        .clk_out (clk_out),
        .clk_en  (clk_en),
        .cur_div (cur_div),
        .running (running)
    );

    wire [4:0] obs = {running, clk_out, clk_en, cfg.cfg_ready, cfg.cfg_err};

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Reset values, then idle STOP with en low.
    task automatic test_reset();
        rst           = 1'b1;
        en            = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;
        step();
        step();
        vectors++;
        if (obs !== 5'b00010 || cur_div !== 8'd4) begin
            miscompares++;
            $display("FAIL reset: obs=%b cur_div=%0d, expected obs=00010 cur_div=4", obs, cur_div);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (obs !== 5'b00010 || cur_div !== 8'd4) begin
            miscompares++;
            $display("FAIL idle_after_reset: obs=%b cur_div=%0d, expected obs=00010 cur_div=4", obs, cur_div);
        end
    endtask

    // DEFAULT_DIV=4: clk_out 1,1,0,0; clk_en on every 4th cycle; then stop.
    task automatic test_default_div();
        bit       pat4 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit       en4  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] exp_obs;
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_obs = {1'b1, pat4[k % 4], en4[k % 4], 1'b1, 1'b0};
            vectors++;
            if (obs !== exp_obs || cur_div !== 8'd4) begin
                miscompares++;
                $display("FAIL div4 k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=4", k, obs, cur_div, exp_obs);
            end
        end
        en = 1'b0;                       // current cycle is a boundary
        step();
        vectors++;
        if (obs !== 5'b00010 || cur_div !== 8'd4) begin
            miscompares++;
            $display("FAIL div4_stop: obs=%b cur_div=%0d, expected obs=00010 cur_div=4", obs, cur_div);
        end
    endtask

    // Program ratio 5 in STOP, then run: 1,1,0,0,0.
    task automatic test_program_stop();
        bit       pat5 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bit       en5  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] exp_obs;
        cfg.cfg_div   = 8'd5;
        cfg.cfg_valid = 1'b1;
        step();
        cfg.cfg_valid = 1'b0;
        vectors++;
        if (obs !== 5'b00010 || cur_div !== 8'd5) begin
            miscompares++;
            $display("FAIL stop_load5: obs=%b cur_div=%0d, expected obs=00010 cur_div=5", obs, cur_div);
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            exp_obs = {1'b1, pat5[k % 5], en5[k % 5], 1'b1, 1'b0};
            vectors++;
            if (obs !== exp_obs || cur_div !== 8'd5) begin
                miscompares++;
                $display("FAIL div5 k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=5", k, obs, cur_div, exp_obs);
            end
        end
        en = 1'b0;
        step();
        vectors++;
        if (obs !== 5'b00010) begin
            miscompares++;
            $display("FAIL div5_stop: obs=%b, expected obs=00010", obs);
        end
    endtask

    // RUN at 4, accept 3 at count=1: two more cycles at 4, then 1,0,0.
    task automatic test_switch();
        bit       pat3 [3] = '{1'b1, 1'b0, 1'b0};
        bit       en3  [3] = '{1'b0, 1'b0, 1'b1};
        logic [4:0] exp_obs;
        logic [4:0] pre [4] = '{5'b11010, 5'b11010, 5'b10000, 5'b10100};
        cfg.cfg_div   = 8'd4;
        cfg.cfg_valid = 1'b1;
        step();
        cfg.cfg_valid = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 1) begin           // count=1: request ratio 3
                cfg.cfg_div   = 8'd3;
                cfg.cfg_valid = 1'b1;
            end else begin
                cfg.cfg_valid = 1'b0;
            end
            vectors++;
            if (obs !== pre[k] || cur_div !== 8'd4) begin
                miscompares++;
                $display("FAIL switch_pre k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=4", k, obs, cur_div, pre[k]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            exp_obs = {1'b1, pat3[k % 3], en3[k % 3], 1'b1, 1'b0};
            vectors++;
            if (obs !== exp_obs || cur_div !== 8'd3) begin
                miscompares++;
                $display("FAIL switch_div3 k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=3", k, obs, cur_div, exp_obs);
            end
        end
    endtask

    // Zero ratio while running at 3 (entered at count=2 boundary).
    task automatic test_cfg_zero();
        logic [4:0] exp_z [4] = '{5'b11010, 5'b10011, 5'b10110, 5'b11010};
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin           // count=0: request ratio 0
                cfg.cfg_div   = 8'd0;
                cfg.cfg_valid = 1'b1;
            end else begin
                cfg.cfg_valid = 1'b0;
            end
            vectors++;
            if (obs !== exp_z[k] || cur_div !== 8'd3) begin
                miscompares++;
                $display("FAIL cfg_zero k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=3", k, obs, cur_div, exp_z[k]);
            end
        end
    endtask

    // en drop mid-period at ratio 6, then ratio 1, then stop+load on boundary.
    task automatic test_stop_mid_period();
        logic [4:0] exp6 [7] = '{5'b11010, 5'b11010, 5'b11010, 5'b10010,
                                 5'b10010, 5'b10110, 5'b00010};
        // Currently at count=0 of ratio 3: drop en, period finishes.
        en = 1'b0;
        repeat (3) step();
        vectors++;
        if (obs !== 5'b00010) begin
            miscompares++;
            $display("FAIL stop_div3: obs=%b, expected obs=00010", obs);
        end
        cfg.cfg_div   = 8'd6;
        cfg.cfg_valid = 1'b1;
        step();
        cfg.cfg_valid = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 1) en = 1'b0;      // count=1: drop en
            vectors++;
            if (obs !== exp6[k] || cur_div !== 8'd6) begin
                miscompares++;
                $display("FAIL div6_drop k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=6", k, obs, cur_div, exp6[k]);
            end
        end
        cfg.cfg_div   = 8'd1;
        cfg.cfg_valid = 1'b1;
        step();
        cfg.cfg_valid = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (obs !== 5'b11110 || cur_div !== 8'd1) begin
                miscompares++;
                $display("FAIL div1 k=%0d: obs=%b cur_div=%0d, expected obs=11110 cur_div=1", k, obs, cur_div);
            end
        end
        // Ratio 1: every cycle is a boundary. en=0 plus accept -> STOP load.
        en            = 1'b0;
        cfg.cfg_div   = 8'd7;
        cfg.cfg_valid = 1'b1;
        step();
        cfg.cfg_valid = 1'b0;
        vectors++;
        if (obs !== 5'b00010 || cur_div !== 8'd7) begin
            miscompares++;
            $display("FAIL boundary_stop_load: obs=%b cur_div=%0d, expected obs=00010 cur_div=7", obs, cur_div);
        end
    endtask

    // Reset while SWITCH is pending: pending ratio must be discarded.
    task automatic test_reset_mid_switch();
        bit       pat4 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit       en4  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] exp_obs;
        logic [4:0] exp7 [3] = '{5'b11010, 5'b11000, 5'b11000};
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) begin           // count=0 at ratio 7: request ratio 2
                cfg.cfg_div   = 8'd2;
                cfg.cfg_valid = 1'b1;
            end else begin
                cfg.cfg_valid = 1'b0;
            end
            vectors++;
            if (obs !== exp7[k] || cur_div !== 8'd7) begin
                miscompares++;
                $display("FAIL pre_reset k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=7", k, obs, cur_div, exp7[k]);
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 5'b00010 || cur_div !== 8'd4) begin
            miscompares++;
            $display("FAIL async_reset: obs=%b cur_div=%0d, expected obs=00010 cur_div=4", obs, cur_div);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_obs = {1'b1, pat4[k % 4], en4[k % 4], 1'b1, 1'b0};
            vectors++;
            if (obs !== exp_obs || cur_div !== 8'd4) begin
                miscompares++;
                $display("FAIL post_reset k=%0d: obs=%b cur_div=%0d, expected obs=%b cur_div=4", k, obs, cur_div, exp_obs);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_program_stop();
        test_switch();
        test_cfg_zero();
        test_stop_mid_period();
        test_reset_mid_switch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clk_div_ctrl

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time programmable clock-enable/divided-clock generator with a controller that sequences start, stop and ratio changes.
- Ratio changes and stops take effect only at output-period boundaries, so no runt or stretched period is ever produced.
- Sits beside the fixed-ratio divider: used where the ratio is programmed by software or an upstream FSM rather than fixed at elaboration.
- Outputs are registered and safe to use as a clock enable in the clk_in domain.

Parameters:
- CNT_W, 8, width of divide ratio and period counter; legal ratios 1..2^CNT_W-1.
- DEFAULT_DIV, 4, ratio loaded at reset; must be 1..2^CNT_W-1.

Ports:
- clk_in  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request; level-sensitive.
- cfg_div  input  CNT_W  requested divide ratio.
- cfg_valid  input  1  cfg_div valid.
- cfg_ready  output  1  request accepted when cfg_valid && cfg_ready at a rising edge.
- cfg_err  output  1  one-cycle pulse: accepted request had cfg_div==0.
- clk_out  output  1  divided clock, registered.
- clk_en  output  1  one-cycle pulse on the last clk_in cycle of each output period.
- cur_div  output  CNT_W  ratio currently in effect.
- running  output  1  high in RUN or SWITCH.

Behaviour:
- Reset (async assert) values:
  - state=STOP, count=0, cur_div=DEFAULT_DIV, pending cleared.
  - clk_out=0, clk_en=0, cfg_err=0, cfg_ready=1, running=0.
  - Reset mid-operation discards any pending ratio.
- All outputs are registered, with no combinational path from inputs. Each output is a function of (state, count, cur_div) in the same cycle.
- clk_out=1 iff running and count < cur_div>>1. Exception: cur_div==1 gives clk_out=1 constantly while running.
  - Example: DIV=5 gives 2 high, 3 low.
- clk_en=1 iff running and count==cur_div-1; with cur_div==1 it is high every running cycle.
- count increments by 1 while running and wraps to 0 after cur_div-1.
- STOP:
  - count held at 0; clk_out=0.
  - cfg_ready=1. A valid accepted cfg_div updates cur_div on the next cycle.
  - en=1 sampled: next cycle state=RUN, count=0, clk_out=1 (period starts high).
  - Latency from en rising to first clk_out high is 1 cycle.
- RUN:
  - cfg_ready=1. An accepted nonzero cfg_div is stored in pending; next cycle state=SWITCH and cfg_ready=0.
  - This applies even if the accept happens on a boundary cycle; the switch then occurs at the following boundary, never the same one.
  - The old ratio stays in effect until the boundary.
- SWITCH:
  - cfg_ready=0; count continues with the old cur_div.
  - On the cycle with count==cur_div-1: next cycle cur_div=pending, count=0, state=RUN (or STOP, see en), cfg_ready=1.
- Stop: en is sampled only on boundary cycles (count==cur_div-1).
  - en==0 there: next cycle state=STOP, clk_out=0, count=0.
  - A pending switch still commits cur_div at that boundary.
  - en dropping mid-period completes the current period.
- cfg_div==0:
  - The handshake completes normally (ready unchanged).
  - cfg_err pulses the next cycle; cur_div and state are unchanged.
- Simultaneous en=0 and cfg accept on a boundary in RUN: state goes to STOP and the new ratio is loaded into cur_div (STOP-style load).
- Wrap-around: count never exceeds cur_div-1.

Test Plan:
- Reset then en=1 (DEFAULT_DIV=4) -> running=1 next cycle; clk_out pattern 1,1,0,0 repeating; clk_en high on each 4th cycle; cur_div=4.
- In STOP, program cfg_div=5 then en=1 -> clk_out 1,1,0,0,0 repeating; clk_en every 5 cycles; cur_div=5.
- While RUN at DIV=4, count=1, accept cfg_div=3 -> cfg_ready=0 until the boundary; 2 more cycles at DIV=4, then cur_div=3, pattern 1,0,0, cfg_ready=1.
- Accept cfg_div=0 while RUN -> cfg_err=1 for exactly 1 cycle; cur_div and clk_out pattern unchanged.
- Drop en at count=1 with DIV=6 -> period completes (4 more cycles), then clk_out=0, running=0, count=0; cfg_div=1 then en=1 -> clk_out constant 1, clk_en every cycle.
- Assert rst mid-SWITCH -> immediately clk_out=0, running=0, cfg_ready=1, cur_div=DEFAULT_DIV; the pending ratio is never applied after release.
